// File: rtl/lutram_bcast_fifo_pkg.sv
// Shared constants and helpers for the broadcast FIFO and its dual-read LUTRAM.
package lutram_bcast_fifo_pkg;

   localparam int NUM_RD_PORTS = 2;

   function automatic bit is_pow2(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/lutram_bcast_fifo_lutram.sv
// lutram_dual: one synchronous write port, two asynchronous read ports (MLAB style).
// i_clr forces both read outputs to zero without touching the array contents.
module lutram_dual
   import lutram_bcast_fifo_pkg::*;
#(
   parameter int WIDTH     = 256,
   parameter int DEPTH     = 16,
   parameter int LOG_DEPTH = $clog2(DEPTH)
) (
   input  logic                 i_clk,
   input  logic                 i_clr,
   input  logic                 i_wen,
   input  logic [LOG_DEPTH-1:0] i_waddr,
   input  logic [WIDTH-1:0]     i_din,
   input  logic [LOG_DEPTH-1:0] i_raddr_0,
   input  logic [LOG_DEPTH-1:0] i_raddr_1,
   output logic [WIDTH-1:0]     o_dout_0,
   output logic [WIDTH-1:0]     o_dout_1
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_wen) begin
         r_mem[i_waddr] <= i_din;
      end
   end

   assign o_dout_0 = i_clr ? '0 : r_mem[i_raddr_0];
   assign o_dout_1 = i_clr ? '0 : r_mem[i_raddr_1];

endmodule

// File: rtl/lutram_bcast_fifo.sv
// Single-writer, dual-reader broadcast FIFO: every accepted word reaches both read
// ports, and a slot is reused only once both readers have moved past it.
module lutram_bcast_fifo
   import lutram_bcast_fifo_pkg::*;
#(
   parameter int WIDTH     = 256,
   parameter int DEPTH     = 16,
   parameter int LOG_DEPTH = $clog2(DEPTH)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_wr_valid,
   input  logic [WIDTH-1:0]     i_wr_data,
   output logic                 o_wr_ready,
   output logic                 o_rd0_valid,
   output logic [WIDTH-1:0]     o_rd0_data,
   input  logic                 i_rd0_ready,
   output logic                 o_rd1_valid,
   output logic [WIDTH-1:0]     o_rd1_data,
   input  logic                 i_rd1_ready,
   output logic [LOG_DEPTH:0]   o_level0,
   output logic [LOG_DEPTH:0]   o_level1,
   output logic                 o_ovf_err
);

   localparam int PTR_W = LOG_DEPTH + 1;
   localparam logic [PTR_W-1:0] FULL_LEVEL = PTR_W'(DEPTH);

   if (!is_pow2(DEPTH)) begin : g_bad_depth
      $error("lutram_bcast_fifo: DEPTH must be a power of two >= 2");
   end

   logic [PTR_W-1:0]        r_wptr;
   logic                    r_ovf_err;
   logic [PTR_W-1:0]        w_level  [NUM_RD_PORTS];
   logic [LOG_DEPTH-1:0]    w_raddr  [NUM_RD_PORTS];
   logic [WIDTH-1:0]        w_dout   [NUM_RD_PORTS];
   logic [NUM_RD_PORTS-1:0] w_rd_ready;
   logic [NUM_RD_PORTS-1:0] w_rd_valid;
   logic                    w_full;
   logic                    w_wr_ready;
   logic                    w_wen;

   assign w_rd_ready = {i_rd1_ready, i_rd0_ready};

   // Each reader owns its pointer; level and validity follow from pointer distance alone.
   for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_port
      logic [PTR_W-1:0] r_rptr;
      logic             w_pop;

      assign w_level[gi]    = r_wptr - r_rptr;
      assign w_rd_valid[gi] = (w_level[gi] != '0);
      assign w_pop          = w_rd_valid[gi] & w_rd_ready[gi];
      assign w_raddr[gi]    = r_rptr[LOG_DEPTH-1:0];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_rptr <= '0;
         end else if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
      end
   end

   // Full looks only at registered pointers, so a same-cycle pop never admits a write.
   always_comb begin
      w_full = 1'b0;
      for (int k = 0; k < NUM_RD_PORTS; k++) begin
         if (w_level[k] == FULL_LEVEL) begin
            w_full = 1'b1;
         end
      end
   end

   assign w_wr_ready = ~w_full;
   assign w_wen      = i_wr_valid & w_wr_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr    <= '0;
         r_ovf_err <= 1'b0;
      end else begin
         if (w_wen) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (i_wr_valid & ~w_wr_ready) begin
            r_ovf_err <= 1'b1;
         end
      end
   end

   lutram_dual #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .LOG_DEPTH (LOG_DEPTH)
   ) u_ram (
      .i_clk     (i_clk),
      .i_clr     (1'b0),
      .i_wen     (w_wen),
      .i_waddr   (r_wptr[LOG_DEPTH-1:0]),
      .i_din     (i_wr_data),
      .i_raddr_0 (w_raddr[0]),
      .i_raddr_1 (w_raddr[1]),
      .o_dout_0  (w_dout[0]),
      .o_dout_1  (w_dout[1])
   );

   assign o_wr_ready  = w_wr_ready;
   assign o_rd0_valid = w_rd_valid[0];
   assign o_rd1_valid = w_rd_valid[1];
   assign o_rd0_data  = w_dout[0];
   assign o_rd1_data  = w_dout[1];
   assign o_level0    = w_level[0];
   assign o_level1    = w_level[1];
   assign o_ovf_err   = r_ovf_err;

endmodule

// File: tb/tb_lutram_bcast_fifo.sv
// Bench for lutram_bcast_fifo: directed vector table, hand-written corner sequences,
// and a randomized run checked against a queue-based model of the two consumers.
module tb_lutram_bcast_fifo;

   localparam int WIDTH = 256;
   localparam int DEPTH = 16;
   localparam int LOGD  = 4;

   logic              i_clk;
   logic              i_rst_n;
   logic              i_wr_valid;
   logic [WIDTH-1:0]  i_wr_data;
   logic              o_wr_ready;
   logic              o_rd0_valid;
   logic [WIDTH-1:0]  o_rd0_data;
   logic              i_rd0_ready;
   logic              o_rd1_valid;
   logic [WIDTH-1:0]  o_rd1_data;
   logic              i_rd1_ready;
   logic [LOGD:0]     o_level0;
   logic [LOGD:0]     o_level1;
   logic              o_ovf_err;

   lutram_bcast_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_wr_valid  (i_wr_valid),
      .i_wr_data   (i_wr_data),
      .o_wr_ready  (o_wr_ready),
      .o_rd0_valid (o_rd0_valid),
      .o_rd0_data  (o_rd0_data),
      .i_rd0_ready (i_rd0_ready),
      .o_rd1_valid (o_rd1_valid),
      .o_rd1_data  (o_rd1_data),
      .i_rd1_ready (i_rd1_ready),
      .o_level0    (o_level0),
      .o_level1    (o_level1),
      .o_ovf_err   (o_ovf_err)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: one queue of pending words per consumer.
   logic [WIDTH-1:0] q0[$];
   logic [WIDTH-1:0] q1[$];
   bit               m_ovf;

   typedef struct {
      bit         wv;
      logic [7:0] d;
      bit         r0;
      bit         r1;
      bit         e_rdy;
      bit         e_v0;
      bit         e_v1;
      int         e_l0;
      int         e_l1;
      logic [7:0] e_d0;
      logic [7:0] e_d1;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input bit wv, input logic [WIDTH-1:0] d, input bit r0, input bit r1);
      i_wr_valid  = wv;
      i_wr_data   = d;
      i_rd0_ready = r0;
      i_rd1_ready = r1;
      #1;
   endtask

   // Advance one clock edge; the model applies the same cycle's transfer.
   task automatic tick();
      bit full;
      bit acc;
      bit p0;
      bit p1;
      logic [WIDTH-1:0] d;
      full = (q0.size() == DEPTH) || (q1.size() == DEPTH);
      acc  = i_wr_valid && !full;
      p0   = i_rd0_ready && (q0.size() != 0);
      p1   = i_rd1_ready && (q1.size() != 0);
      d    = i_wr_data;
      if (i_wr_valid && full) m_ovf = 1'b1;
      @(posedge i_clk);
      #1;
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (acc) begin
         q0.push_back(d);
         q1.push_back(d);
      end
   endtask

   task automatic cmp_model();
      chk("m_wr_ready", 256'(o_wr_ready), 256'((q0.size() != DEPTH) && (q1.size() != DEPTH)));
      chk("m_rd0_valid", 256'(o_rd0_valid), 256'(q0.size() != 0));
      chk("m_rd1_valid", 256'(o_rd1_valid), 256'(q1.size() != 0));
      chk("m_level0", 256'(o_level0), 256'(q0.size()));
      chk("m_level1", 256'(o_level1), 256'(q1.size()));
      chk("m_ovf_err", 256'(o_ovf_err), 256'(m_ovf));
      chk("m_level0_bound", 256'(o_level0 <= DEPTH), 256'(1));
      chk("m_level1_bound", 256'(o_level1 <= DEPTH), 256'(1));
      if (q0.size() != 0) chk("m_rd0_data", o_rd0_data, q0[0]);
      if (q1.size() != 0) chk("m_rd1_data", o_rd1_data, q1[0]);
   endtask

   task automatic do_reset();
      drive(1'b0, '0, 1'b0, 1'b0);
      i_rst_n = 1'b0;
      q0.delete();
      q1.delete();
      m_ovf = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
   endtask

   function automatic logic [WIDTH-1:0] rand_word();
      logic [WIDTH-1:0] w;
      for (int i = 0; i < WIDTH / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   initial begin
      int p_wr;
      int p_r0;
      int p_r1;
      i_rst_n = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0);
      m_ovf = 1'b0;

      tbl[0] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1, 8'hA1, 8'hA1};
      tbl[1] = '{1'b1, 8'hB2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1, 2, 8'hB2, 8'hA1};
      tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1, 8'h00, 8'hB2};
      tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 8'h00, 8'h00};
      tbl[4] = '{1'b1, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1, 8'hC3, 8'hC3};
      tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0, 8'hC3, 8'h00};

      // Async reset mid-stream with five words pending.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, WIDTH'(8'h50 + i), 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      chk("pre_reset_level0", 256'(o_level0), 256'(5));
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("rst_wr_ready", 256'(o_wr_ready), 256'(1));
      chk("rst_rd0_valid", 256'(o_rd0_valid), 256'(0));
      chk("rst_rd1_valid", 256'(o_rd1_valid), 256'(0));
      chk("rst_level0", 256'(o_level0), 256'(0));
      chk("rst_level1", 256'(o_level1), 256'(0));
      chk("rst_ovf_err", 256'(o_ovf_err), 256'(0));
      $display("txn reset_mid_stream level0=%0d level1=%0d", o_level0, o_level1);
      do_reset();

      // Directed vector table, outputs checked after each edge.
      foreach (tbl[i]) begin
         drive(tbl[i].wv, WIDTH'(tbl[i].d), tbl[i].r0, tbl[i].r1);
         tick();
         chk("vec_wr_ready", 256'(o_wr_ready), 256'(tbl[i].e_rdy));
         chk("vec_rd0_valid", 256'(o_rd0_valid), 256'(tbl[i].e_v0));
         chk("vec_rd1_valid", 256'(o_rd1_valid), 256'(tbl[i].e_v1));
         chk("vec_level0", 256'(o_level0), 256'(tbl[i].e_l0));
         chk("vec_level1", 256'(o_level1), 256'(tbl[i].e_l1));
         if (tbl[i].e_v0) chk("vec_rd0_data", o_rd0_data, WIDTH'(tbl[i].e_d0));
         if (tbl[i].e_v1) chk("vec_rd1_data", o_rd1_data, WIDTH'(tbl[i].e_d1));
         $display("txn vec%0d wv=%0d r0=%0d r1=%0d -> l0=%0d l1=%0d", i, tbl[i].wv,
                  tbl[i].r0, tbl[i].r1, o_level0, o_level1);
      end

      // Skew: fill, drain port 0 only, then one pop on port 1 frees a slot.
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, WIDTH'(16'h100 + i), 1'b0, 1'b0);
         tick();
      end
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, '0, 1'b1, 1'b0);
         tick();
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      chk("skew_level0", 256'(o_level0), 256'(0));
      chk("skew_level1", 256'(o_level1), 256'(DEPTH));
      chk("skew_wr_ready", 256'(o_wr_ready), 256'(0));
      chk("skew_rd1_data", o_rd1_data, WIDTH'(16'h100));
      drive(1'b0, '0, 1'b0, 1'b1);
      tick();
      chk("skew_pop_wr_ready", 256'(o_wr_ready), 256'(1));
      chk("skew_pop_level1", 256'(o_level1), 256'(DEPTH - 1));
      chk("skew_pop_rd1_data", o_rd1_data, WIDTH'(16'h101));
      $display("txn skew level0=%0d level1=%0d wr_ready=%0d", o_level0, o_level1, o_wr_ready);

      // Full: a pop in the same cycle must not admit the write.
      drive(1'b1, WIDTH'(16'h1FF), 1'b0, 1'b0);
      tick();
      chk("full_level1", 256'(o_level1), 256'(DEPTH));
      drive(1'b1, WIDTH'(16'h2EE), 1'b0, 1'b1);
      chk("full_wr_ready_pre", 256'(o_wr_ready), 256'(0));
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      chk("full_ovf_err", 256'(o_ovf_err), 256'(1));
      chk("full_level1_after", 256'(o_level1), 256'(DEPTH - 1));
      chk("full_level0_after", 256'(o_level0), 256'(1));
      chk("full_rd0_data", o_rd0_data, WIDTH'(16'h1FF));
      cmp_model();
      $display("txn full_drop ovf=%0d level1=%0d", o_ovf_err, o_level1);

      // Wrap: 40-word stream with both readers always ready.
      do_reset();
      chk("wrap_ovf_cleared", 256'(o_ovf_err), 256'(0));
      for (int c = 0; c < 44; c++) begin
         drive(c < 40, WIDTH'(c), 1'b1, 1'b1);
         if (c == 0) begin
            chk("wrap_first_rd0_valid", 256'(o_rd0_valid), 256'(0));
         end else if (c <= 40) begin
            chk("wrap_rd0_valid", 256'(o_rd0_valid), 256'(1));
            chk("wrap_rd1_valid", 256'(o_rd1_valid), 256'(1));
            chk("wrap_rd0_data", o_rd0_data, WIDTH'(c - 1));
            chk("wrap_rd1_data", o_rd1_data, WIDTH'(c - 1));
         end
         tick();
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      chk("wrap_level0_end", 256'(o_level0), 256'(0));
      chk("wrap_level1_end", 256'(o_level1), 256'(0));
      $display("txn wrap streamed 40 words");

      // Random traffic against the queue model, bias changed every 500 cycles.
      do_reset();
      p_wr = 50;
      p_r0 = 50;
      p_r1 = 50;
      for (int c = 0; c < 10000; c++) begin
         if (c % 500 == 0) begin
            p_wr = $urandom_range(20, 95);
            p_r0 = $urandom_range(5, 95);
            p_r1 = $urandom_range(5, 95);
         end
         drive($urandom_range(0, 99) < p_wr, rand_word(),
               $urandom_range(0, 99) < p_r0, $urandom_range(0, 99) < p_r1);
         cmp_model();
         tick();
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      cmp_model();
      $display("txn random 10000 cycles level0=%0d level1=%0d ovf=%0d", o_level0, o_level1,
               o_ovf_err);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
